// File: rtl/staged_register_if.sv
// Load bus for staged_register: EI request and captured word in, visible contents and busy/done status out.
interface staged_register_if #(
  parameter int WIDTH = 8
);
  logic             EI;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  // Handshake: the requester holds EI high with data_in valid; the register accepts it on the first rising
  // edge at which it is idle, keeps busy high for the whole load and pulses done for one cycle once data_out is final.
  modport master (output EI, data_in, input data_out, busy, done);
  modport slave  (input EI, data_in, output data_out, busy, done);
endinterface

// File: rtl/staged_register.sv
// Visible CPU register that settles one bit every STEP cycles so a human can watch the load.
// STAGED_REGISTER_STAGED_LOAD_EN enables the staged FSM; without it the word loads in a single edge.
module staged_register #(
  parameter int WIDTH     = 8,
  parameter int STEP      = 5,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  staged_register_if.slave  bus,
  output logic              dbg_state
);

`ifdef STAGED_REGISTER_STAGED_LOAD_EN
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [IDX_W-1:0]  FIRST_IDX = (MSB_FIRST != 0) ? IDX_W'(WIDTH - 1) : '0;
  localparam logic [IDX_W-1:0]  LAST_IDX  = (MSB_FIRST != 0) ? '0 : IDX_W'(WIDTH - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      step_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      step_q   <= step_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    step_d   = step_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.EI) begin
          shadow_d = bus.data_in;
          idx_d    = FIRST_IDX;
          step_d   = '0;
          busy_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // EI and data_in are deliberately not looked at here: the shadow copy owns the word until done.
        if (step_q == STEP_LAST) begin
          data_d[idx_q] = shadow_q[idx_q];
          step_d        = '0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (MSB_FIRST != 0) begin
            idx_d = idx_q - IDX_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign dbg_state    = state_q;

`else
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  // STEP and MSB_FIRST only shape the staged load, which is absent in this build.
  logic             unused_cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= bus.EI;
      if (bus.EI) begin
        data_q <= bus.data_in;
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.busy     = 1'b0;
  assign bus.done     = done_q;
  assign dbg_state    = 1'b0;
  assign unused_cfg   = (STEP > 0) ^ (MSB_FIRST != 0);
`endif

endmodule

// File: tb/tb_staged_register.sv
// Scoreboard bench for staged_register: directed loads push expected words, a negedge monitor checks each done.
module tb_staged_register;
  localparam int W    = 8;
  localparam int STEP = 5;

  logic clk = 1'b0;
  logic rst;
  logic dbg_a, dbg_b;

  int n_cmp      = 0;
  int n_err      = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int busy_cnt_b = 0;
  int busy_seen  = 0;
  int busy_base;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  logic [W-1:0] lsb_tab [8] = '{8'h01, 8'h01, 8'h05, 8'h05, 8'h05, 8'h25, 8'h25, 8'hA5};
  logic [W-1:0] msb_tab [8] = '{8'h25, 8'h25, 8'h25, 8'h35, 8'h3D, 8'h3D, 8'h3D, 8'h3C};

  staged_register_if #(.WIDTH(W)) bus_a ();
  staged_register_if #(.WIDTH(W)) bus_b ();

  staged_register #(.WIDTH(W), .STEP(STEP), .MSB_FIRST(0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_a),
    .dbg_state (dbg_a)
  );

  staged_register #(.WIDTH(W), .STEP(STEP), .MSB_FIRST(1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_b),
    .dbg_state (dbg_b)
  );

  // Clock and reset-free clocking; reset is driven by the stimulus block.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks: raise EI for one edge, then scramble data_in so a missing shadow copy shows up.
  task automatic start_a(input logic [W-1:0] d, input bit expect_done);
    bus_a.EI      = 1'b1;
    bus_a.data_in = d;
    if (expect_done) exp_a.push_back(d);
    @(negedge clk);
    bus_a.EI      = 1'b0;
    bus_a.data_in = ~d;
  endtask

  task automatic start_b(input logic [W-1:0] d);
    bus_b.EI      = 1'b1;
    bus_b.data_in = d;
    exp_b.push_back(d);
    @(negedge clk);
    bus_b.EI      = 1'b0;
    bus_b.data_in = ~d;
  endtask

  // Monitor: every done pulse must match the oldest outstanding load.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus_a.done === 1'b1) begin
        done_cnt_a++;
        check("done_a_expected", 32'(exp_a.size() != 0), 32'(1));
        if (exp_a.size() != 0) check("done_a_data", 32'(bus_a.data_out), 32'(exp_a.pop_front()));
      end
      if (bus_b.done === 1'b1) begin
        done_cnt_b++;
        check("done_b_expected", 32'(exp_b.size() != 0), 32'(1));
        if (exp_b.size() != 0) check("done_b_data", 32'(bus_b.data_out), 32'(exp_b.pop_front()));
      end
      if (bus_b.busy === 1'b1) busy_cnt_b++;
      if (bus_a.busy === 1'b1 || bus_b.busy === 1'b1) busy_seen++;
    end
  end

  initial begin
    rst           = 1'b1;
    bus_a.EI      = 1'b1;
    bus_a.data_in = 8'hFF;
    bus_b.EI      = 1'b1;
    bus_b.data_in = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_data_a", 32'(bus_a.data_out), 32'(0));
    check("rst_busy_a", 32'(bus_a.busy), 32'(0));
    check("rst_done_a", 32'(bus_a.done), 32'(0));
    check("rst_data_b", 32'(bus_b.data_out), 32'(0));
    check("rst_state_a", 32'(dbg_a), 32'(0));
    rst           = 1'b0;
    bus_a.EI      = 1'b0;
    bus_a.data_in = 8'h00;
    bus_b.EI      = 1'b0;
    bus_b.data_in = 8'h00;
    @(negedge clk);

`ifndef STAGED_REGISTER_STAGED_LOAD_EN
    start_a(8'h5A, 1'b1);
    check("off_load_5a", 32'(bus_a.data_out), 32'(8'h5A));
    check("off_done_high", 32'(bus_a.done), 32'(1));
    check("off_busy_low", 32'(bus_a.busy), 32'(0));
    @(negedge clk);
    check("off_done_low", 32'(bus_a.done), 32'(0));
    check("off_hold_5a", 32'(bus_a.data_out), 32'(8'h5A));
    // EI held high over two edges loads twice, done stays high for both following cycles.
    bus_a.EI      = 1'b1;
    bus_a.data_in = 8'h3C;
    exp_a.push_back(8'h3C);
    @(negedge clk);
    check("off_load_3c", 32'(bus_a.data_out), 32'(8'h3C));
    bus_a.data_in = 8'hC3;
    exp_a.push_back(8'hC3);
    @(negedge clk);
    check("off_load_c3", 32'(bus_a.data_out), 32'(8'hC3));
    check("off_done_held", 32'(bus_a.done), 32'(1));
    bus_a.EI      = 1'b0;
    bus_a.data_in = 8'hFF;
    repeat (3) @(negedge clk);
    check("off_hold_c3", 32'(bus_a.data_out), 32'(8'hC3));
    check("off_done_idle", 32'(bus_a.done), 32'(0));
    check("off_done_count", 32'(done_cnt_a), 32'(3));
    check("off_busy_never", 32'(busy_seen), 32'(0));
`else
    // LSB-first 0xA5 from 0x00.
    start_a(8'hA5, 1'b1);
    check("lsb_busy_rise", 32'(bus_a.busy), 32'(1));
    check("lsb_state_load", 32'(dbg_a), 32'(1));
    for (int k = 0; k < 8; k++) begin
      repeat (STEP) @(negedge clk);
      check("lsb_step", 32'(bus_a.data_out), 32'(lsb_tab[k]));
      check("lsb_busy", 32'(bus_a.busy), 32'(k < 7));
      check("lsb_done", 32'(bus_a.done), 32'(k == 7));
    end
    @(negedge clk);
    check("lsb_done_fall", 32'(bus_a.done), 32'(0));
    check("lsb_done_count", 32'(done_cnt_a), 32'(1));

    // MSB-first 0x3C over 0xA5.
    start_b(8'hA5);
    repeat (41) @(negedge clk);
    busy_base = busy_cnt_b;
    start_b(8'h3C);
    for (int k = 0; k < 8; k++) begin
      repeat (STEP) @(negedge clk);
      check("msb_step", 32'(bus_b.data_out), 32'(msb_tab[k]));
    end
    @(negedge clk);
    check("msb_busy_cycles", 32'(busy_cnt_b - busy_base), 32'(40));
    check("msb_done_count", 32'(done_cnt_b), 32'(2));

    // EI pulse while busy must be ignored.
    start_a(8'h0F, 1'b1);
    repeat (7) @(negedge clk);
    bus_a.EI      = 1'b1;
    bus_a.data_in = 8'hF0;
    @(negedge clk);
    bus_a.EI      = 1'b0;
    repeat (32) @(negedge clk);
    check("ign_final", 32'(bus_a.data_out), 32'(8'h0F));
    check("ign_done", 32'(bus_a.done), 32'(1));
    repeat (10) @(negedge clk);
    check("ign_one_done", 32'(done_cnt_a), 32'(2));
    check("ign_no_reload", 32'(bus_a.busy), 32'(0));
    check("ign_state_idle", 32'(dbg_a), 32'(0));

    // Reset in the middle of a load of 0xFF.
    start_a(8'hFF, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_data", 32'(bus_a.data_out), 32'(0));
    check("rst_mid_busy", 32'(bus_a.busy), 32'(0));
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt_a), 32'(2));

    // Fresh load, then a back-to-back request during its done cycle.
    start_a(8'h3C, 1'b1);
    repeat (40) @(negedge clk);
    check("fresh_data", 32'(bus_a.data_out), 32'(8'h3C));
    check("fresh_done", 32'(bus_a.done), 32'(1));
    start_a(8'h81, 1'b1);
    check("b2b_busy", 32'(bus_a.busy), 32'(1));
    check("b2b_done_fall", 32'(bus_a.done), 32'(0));
    repeat (40) @(negedge clk);
    check("b2b_data", 32'(bus_a.data_out), 32'(8'h81));
    @(negedge clk);
    check("b2b_done_count", 32'(done_cnt_a), 32'(4));
`endif

    check("queue_a_drained", 32'(exp_a.size()), 32'(0));
    check("queue_b_drained", 32'(exp_b.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
